rr_or_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 42 ++++
 rtl/rr_or_arbiter.sv | 110 +++++++++++
 tb/tb_rr_or_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index width with a floor of one bit, so a single-entry index still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority pick: first set bit at or above ptr, wrapping to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic [IW:0]    first;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign mask[gi]   = ((IW+1)'(gi) >= {1'b0, ptr});
      assign onehot[gi] = found && (idx == IW'(gi));
    end
  endgenerate

  // Lower half holds only bits at/above ptr; the upper copy supplies the wrap-around.
  assign dbl = {cand, cand & mask};

  always_comb begin
    found = 1'b0;
    first = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        first = (IW+1)'(i);
      end
    end
  end

  assign idx = (first >= (IW+1)'(N)) ? IW'(first - (IW+1)'(N)) : first[IW-1:0];

endmodule

// File: rtl/rr_or_arbiter.sv
// Round-robin arbiter with registered one-hot grant, owner release and a hold limit
// that only bites while another requester is waiting.
module rr_or_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IW       = idx_width(N),
  localparam int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic          any_req,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id
);

  arb_state_t    state_reg, state_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic          valid_reg, valid_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

  logic [N-1:0]  cand;
  logic [N-1:0]  win_onehot;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          take;

  assign any_req = |req;

  // While busy the owner is always excluded: release and preemption both need someone else.
  assign cand = (state_reg == BUSY) ? (req & ~grant_reg) : req;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .cand   (cand),
    .ptr    (ptr_reg),
    .onehot (win_onehot),
    .idx    (win_idx),
    .found  (win_found)
  );

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    valid_next    = valid_reg;
    owner_next    = owner_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    take          = 1'b0;

    case (state_reg)
      IDLE: take = win_found;
      BUSY: begin
        if (!req[owner_reg]) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_next    = IDLE;
            grant_next    = '0;
            valid_next    = 1'b0;
            owner_next    = '0;
            hold_cnt_next = '0;
          end
        end else if (hold_cnt_reg == HW'(MAX_HOLD)) begin
          if (win_found) take = 1'b1;
          else           hold_cnt_next = HW'(1);
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      default: ;
    endcase

    if (take) begin
      state_next    = BUSY;
      grant_next    = win_onehot;
      valid_next    = 1'b1;
      owner_next    = win_idx;
      hold_cnt_next = HW'(1);
      ptr_next      = (win_idx == IW'(N-1)) ? '0 : win_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      valid_reg    <= 1'b0;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      valid_reg    <= valid_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_valid = valid_reg;
  assign grant_id    = owner_reg;

endmodule

// File: tb/tb_rr_or_arbiter.sv
// Directed bench for rr_or_arbiter with N=4, MAX_HOLD=4.
module tb_rr_or_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       any_req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;

  int checks = 0;
  int errors = 0;

  rr_or_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .any_req     (any_req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] id);
    check({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    check({tag, ".valid"}, {7'b0, grant_valid}, {7'b0, |g});
    check({tag, ".id"}, {6'b0, grant_id}, {6'b0, id});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    step();
    check_out("reset", 4'b0000, 2'd0);
    check("reset.any_req", {7'b0, any_req}, 8'h00);
    rst_n = 1'b1;

    // single request and release
    req = 4'b0010;
    #1;
    check("single.any_req", {7'b0, any_req}, 8'h01);
    step();
    check_out("single.grant", 4'b0010, 2'd1);
    req = 4'b0000;
    #1;
    check_out("single.tail", 4'b0010, 2'd1);
    step();
    check_out("single.drop", 4'b0000, 2'd0);

    // full contention: four cycles each, rotating, then wrap
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      step();
      check_out($sformatf("contend%0d", k), 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4));
    end

    // zero-bubble handover
    do_reset();
    req = 4'b0001;
    step();
    check_out("handover.first", 4'b0001, 2'd0);
    req = 4'b0100;
    step();
    check_out("handover.next", 4'b0100, 2'd2);

    // lone owner keeps the grant past the hold limit
    do_reset();
    req = 4'b1000;
    for (int k = 0; k < 12; k++) begin
      step();
      check_out($sformatf("lone%0d", k), 4'b1000, 2'd3);
      check($sformatf("lone%0d.hold", k), 8'(dut.hold_cnt_reg), 8'((k % 4) + 1));
    end

    // pointer fairness and wrap
    do_reset();
    req = 4'b1000;
    step();
    check_out("fair.own3", 4'b1000, 2'd3);
    req = 4'b1001;
    step();
    check_out("fair.nopreempt", 4'b1000, 2'd3);
    req = 4'b0001;
    step();
    check_out("fair.wrap", 4'b0001, 2'd0);
    req = 4'b1000;
    step();
    check_out("fair.back3", 4'b1000, 2'd3);
    req = 4'b0011;
    step();
    check_out("fair.wrap2", 4'b0001, 2'd0);

    // asynchronous reset mid-grant
    do_reset();
    req = 4'b0100;
    step();
    check_out("areset.before", 4'b0100, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("areset.during", 4'b0000, 2'd0);
    rst_n = 1'b1;
    step();
    check_out("areset.after", 4'b0100, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
